// File: rtl/multicycle_alu.sv
// Handshaked execute unit: single-cycle logic/arith/shift ops plus iterative
// shift-add MUL and restoring unsigned DIVU/REMU, with zero/overflow/error flags.
module multicycle_alu #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       alufn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] otp,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010,
        OP_DIVU = 6'b000011, OP_AND = 6'b000100, OP_OR  = 6'b000101,
        OP_XOR  = 6'b000110, OP_REMU = 6'b000111, OP_SLL = 6'b001000,
        OP_SRL  = 6'b001001, OP_SRA = 6'b001010, OP_SLT = 6'b001011
    } op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state;
    logic [SW-1:0]     cnt;
    logic [5:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, hi, lo;

    logic [WIDTH-1:0]   res, sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [SW-1:0]      shamt;
    logic               ovf, bad, iter;

    logic [WIDTH:0]     mul_sum, shifted, div_diff;
    logic [WIDTH-1:0]   hi_n, lo_n, fin_res;
    logic               fin_ovf, fin_err;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle result straight from the input operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        res   = '0;
        ovf   = 1'b0;
        bad   = 1'b0;
        sum   = a + b;
        diff  = a - b;
        prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        shamt = b[SW-1:0];
        iter  = (alufn == OP_DIVU) || (alufn == OP_REMU) || ((alufn == OP_MUL) && !FAST_MUL);
        case (alufn)
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                res = prod[WIDTH-1:0];
                ovf = (prod[2*WIDTH-1:WIDTH] != '0);
            end
            OP_DIVU, OP_REMU: res = '0;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLL: res = a << shamt;
            OP_SRL: res = a >> shamt;
            OP_SRA: res = $unsigned($signed(a) >>> shamt);
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: bad = 1'b1;
        endcase
    end

    // One iteration step; hi/lo hold partial product or remainder/quotient.
    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, a_q};
        shifted  = {hi, lo[WIDTH-1]};
        div_diff = shifted - {1'b0, b_q};
        hi_n     = hi;
        lo_n     = lo;
        if (op_q == OP_MUL) begin
            {hi_n, lo_n} = lo[0] ? {mul_sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            hi_n = div_diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
        end
        fin_res = (op_q == OP_REMU) ? hi_n : lo_n;
        fin_ovf = (op_q == OP_MUL) && (hi_n != '0);
        fin_err = (op_q != OP_MUL) && (b_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            otp      <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= alufn;
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= '0;
                    if (iter) begin
                        hi    <= '0;
                        lo    <= (alufn == OP_MUL) ? b : a;
                        state <= BUSY;
                    end else begin
                        otp      <= res;
                        zero     <= (res == '0);
                        overflow <= ovf;
                        err      <= bad;
                        state    <= DONE;
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        otp      <= fin_res;
                        zero     <= (fin_res == '0);
                        overflow <= fin_ovf;
                        err      <= fin_err;
                        state    <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus randomized ops on an
// iterative-MUL and a fast-MUL instance, compared against an arithmetic reference model.
module tb_multicycle_alu;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid[2], in_ready[2], out_valid[2], out_ready[2];
    logic         zero[2], overflow[2], err[2];
    logic [W-1:0] a[2], b[2], otp[2];
    logic [5:0]   alufn[2];

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_alu #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .alufn(alufn[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .otp(otp[0]), .zero(zero[0]),
        .overflow(overflow[0]), .err(err[0])
    );

    multicycle_alu #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .alufn(alufn[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .otp(otp[1]), .zero(zero[1]),
        .overflow(overflow[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values; u selects iterative (0) or fast (1) MUL.
    function automatic void model(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [5:0] op, output logic [W-1:0] r,
                                  output logic v, output logic e, output int lat);
        longint      s;
        logic [63:0] p;
        logic [4:0]  sh;
        sh  = y[4:0];
        r   = '0;
        v   = 1'b0;
        e   = 1'b0;
        lat = 1;
        case (op)
            6'd0: begin s = longint'($signed(x)) + longint'($signed(y)); r = s[W-1:0];
                        v = (s != longint'($signed(r))); end
            6'd1: begin s = longint'($signed(x)) - longint'($signed(y)); r = s[W-1:0];
                        v = (s != longint'($signed(r))); end
            6'd2: begin p = 64'(x) * 64'(y); r = p[W-1:0]; v = (p >= 64'h1_0000_0000);
                        lat = (u == 0) ? W + 1 : 1; end
            6'd3: begin r = (y == 0) ? '1 : x / y; e = (y == 0); lat = W + 1; end
            6'd4: r = x & y;
            6'd5: r = x | y;
            6'd6: r = x ^ y;
            6'd7: begin r = (y == 0) ? x : x % y; e = (y == 0); lat = W + 1; end
            6'd8: r = x << sh;
            6'd9: r = x >> sh;
            6'd10: r = $signed(x) >>> sh;
            6'd11: r = ($signed(x) < $signed(y)) ? 1 : 0;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic run(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [5:0] op, input string tag);
        logic [W-1:0] er;
        logic ev, ee;
        int el, lat, guard;
        model(u, x, y, op, er, ev, ee, el);
        @(negedge clk);
        a[u] = x; b[u] = y; alufn[u] = op;
        in_valid[u] = 1'b1;
        out_ready[u] = 1'b1;
        guard = 0;
        while (!in_ready[u] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check({tag, " accept"}, 64'(in_ready[u]), 64'd1);
            in_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid[u] = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid[u]) break;
        end
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " otp"}, 64'(otp[u]), 64'(er));
        check({tag, " zero"}, 64'(zero[u]), 64'(er == '0));
        check({tag, " overflow"}, 64'(overflow[u]), 64'(ev));
        check({tag, " err"}, 64'(err[u]), 64'(ee));
        @(posedge clk);
    endtask

    task automatic check_cleared(input int u, input string tag);
        check({tag, " otp"}, 64'(otp[u]), 64'd0);
        check({tag, " flags"}, {61'd0, zero[u], overflow[u], err[u]}, 64'd0);
        check({tag, " out_valid"}, 64'(out_valid[u]), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_r, x, y;
        logic         exp_v, exp_e;
        int           exp_l, k, u, guard;
        logic [5:0]   op;

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            a[i] = '0; b[i] = '0; alufn[i] = '0;
        end

        repeat (3) @(negedge clk);
        check_cleared(0, "reset u0");
        check_cleared(1, "reset u1");
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset u0", 64'(in_ready[0]), 64'd1);
        check("in_ready after reset u1", 64'(in_ready[1]), 64'd1);

        // Reset during an in-flight DIVU discards it and clears the outputs.
        run(0, 32'd3, 32'd5, 6'd0, "pre add");
        @(negedge clk);
        a[0] = 32'd100; b[0] = 32'd7; alufn[0] = 6'd3; in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_cleared(0, "mid-divu reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready after mid reset", 64'(in_ready[0]), 64'd1);
        check("out_valid after mid reset", 64'(out_valid[0]), 64'd0);
        run(0, 32'd3, 32'd4, 6'd0, "add 3+4");

        run(0, 32'h7FFF_FFFF, 32'd1, 6'd0, "add ovf");
        run(0, 32'd5, 32'd5, 6'd1, "sub zero");
        run(0, 32'h0001_0000, 32'h0001_0000, 6'd2, "mul slow");
        run(1, 32'h0001_0000, 32'h0001_0000, 6'd2, "mul fast");
        run(0, 32'd100, 32'd7, 6'd3, "divu");
        run(0, 32'd100, 32'd7, 6'd7, "remu");
        run(0, 32'd9, 32'd0, 6'd3, "divu by 0");
        run(0, 32'd9, 32'd0, 6'd7, "remu by 0");
        run(0, 32'hF000_0000, 32'h0000_0024, 6'd10, "sra");
        run(0, 32'hFFFF_FFFF, 32'd1, 6'd11, "slt");
        run(0, 32'h1234_5678, 32'h9, 6'h3F, "illegal");

        // Back-pressure: result and flags hold while out_ready is low.
        model(0, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd4, exp_r, exp_v, exp_e, exp_l);
        @(negedge clk);
        a[0] = 32'hF0F0_1234; b[0] = 32'h0FF0_FF00; alufn[0] = 6'd4;
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        #1 a[0] = 32'd1; b[0] = 32'd2; alufn[0] = 6'd0;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            guard++;
            if (out_valid[0]) break;
        end
        check("bp latency", 64'(guard), 64'(exp_l));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp otp", 64'(otp[0]), 64'(exp_r));
            check("bp flags", {61'd0, zero[0], overflow[0], err[0]}, {61'd0, exp_r == '0, exp_v, exp_e});
            check("bp out_valid", 64'(out_valid[0]), 64'd1);
            check("bp in_ready", 64'(in_ready[0]), 64'd0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release out_valid", 64'(out_valid[0]), 64'd0);
        check("bp release in_ready", 64'(in_ready[0]), 64'd1);
        check("bp release otp", 64'(otp[0]), 64'(exp_r));

        // Randomized ops across both instances.
        for (int n = 0; n < 300; n++) begin
            u = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 13));
            op = (k < 12) ? 6'(k) : 6'($urandom_range(12, 63));
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = '0;
            run(u, x, y, op, $sformatf("rand%0d op%0d", n, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
